operand_fetch_controller: RTL and testbench
===========================================

Name: operand_fetch_controller

Overview:
AXI read-side loader in front of the systolic array. On start it issues two 64-beat INCR read bursts, one per operand matrix (A, then B). It packs the returned 32-bit words into two flattened 2048-bit operand buffers and holds them stable for the array. Completion is signalled with a level done/error handshake that mirrors the downstream writeback stage.

Parameters:
WORDS, 64, beats per operand burst (arlen = WORDS-1); legal range 2..256
DATA_W, 32, AXI data width and word size
ADDR_W, 12, address width; addresses are in 32-bit word units

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  level request; sampled only in IDLE
base_addr_a  in  ADDR_W  start address of operand A
base_addr_b  in  ADDR_W  start address of operand B
m_axi_araddr  out  ADDR_W  burst start address
m_axi_arburst  out  2  INCR (2'b01) when valid
m_axi_arcache  out  4  4'b0011 when valid
m_axi_arlen  out  8  WORDS-1 when valid
m_axi_arlock  out  1  always 0
m_axi_arprot  out  3  always 3'b000
m_axi_arsize  out  3  3'b010 (4 bytes) when valid
m_axi_arvalid  out  1  address valid
m_axi_arready  in  1  address ready
m_axi_rdata  in  DATA_W  read data
m_axi_rresp  in  2  read response
m_axi_rlast  in  1  last beat of burst
m_axi_rvalid  in  1  read data valid
m_axi_rready  out  1  read data ready
a_out_flat  out  WORDS*DATA_W  operand A; word i at bits [i*32 +: 32]
b_out_flat  out  WORDS*DATA_W  operand B, same packing
busy  out  1  high in every state except IDLE
done  out  1  completion level
error  out  1  sticky fault flag for the current fetch

Behaviour:
- Reset: state IDLE. All outputs 0, including arburst/arcache/arlen/arsize, both flat buffers, done and error. Reset mid-burst aborts immediately; outstanding AXI beats are not tracked.
- All outputs are registered.
- States: IDLE, AR, R, DONE. Internal signals: word_cnt (8b) and sel (0=A, 1=B).
- IDLE:
  - done <= 0.
  - When start=1: latch base_addr_b, set araddr <= base_addr_a, drive the AR fields, arvalid <= 1, word_cnt <= 0, sel <= 0, error <= 0, go to AR.
- AR:
  - Hold arvalid and all AR fields stable until arready.
  - On handshake: arvalid <= 0, rready <= 1, go to R.
  - rvalid is ignored in AR because rready is low.
- R:
  - On each rvalid&&rready beat, write rdata into slot word_cnt of the sel buffer, then word_cnt <= word_cnt+1.
  - rresp != 2'b00 on any beat sets error.
  - rlast must equal (word_cnt == WORDS-1); a mismatch sets error, and the beat is still stored.
  - Termination is by count only; rlast never ends a burst.
  - On the beat with word_cnt == WORDS-1, rready <= 0.
    - If sel=0: sel <= 1, word_cnt <= 0, araddr <= latched base_addr_b, arvalid <= 1, go to AR.
    - If sel=1: done <= 1, go to DONE.
- DONE:
  - done held high.
  - Return to IDLE when start=0; done clears in that IDLE cycle.
  - If start stays high, remain in DONE; there is no auto-restart.
- start is ignored outside IDLE.
- Buffers are not cleared on a new start. Slots are overwritten as beats arrive, and contents are stable from done until the next start.
- Latency with a zero-wait slave (arready high, rvalid continuous):
  - start sampled at cycle 0, arvalid at cycle 1.
  - A beats on cycles 2..WORDS+1.
  - B arvalid at WORDS+2.
  - done high at cycle 2*WORDS+3 (131 for WORDS=64).
- Backpressure: rvalid gaps stall word_cnt with no effect on stored data. arready held low keeps arvalid high indefinitely.
- araddr is not incremented; the slave performs INCR addressing.

Decomposition:
- Shared package (the writeback stage uses the same constants):
  - AXI constants: BURST_INCR=2'b01, CACHE_DEF=4'b0011, SIZE_4B=3'b010, RESP_OKAY=2'b00.
  - State enum.
  - WORD_W=32.
  - ADDR_W default.
- Sub-module: none required. Optionally factor the per-beat slot write into operand_buffer (WORDS x DATA_W register bank with write-enable and index).

Test Plan:
1. Zero-wait slave, base_a=0x100, base_b=0x200, A word i = 0xA000_0000+i, B word i = 0xB000_0000+i -> araddr 0x100 then 0x200, arlen=63, arsize=2, arburst=1; a_out_flat[i*32+:32] = 0xA000_0000+i, likewise B; done at cycle 131; error=0.
2. Random rvalid gaps (~30%) and arready delayed 5 cycles -> identical buffers; arvalid and AR fields stable through the wait; exactly 128 beats accepted.
3. rresp=2'b10 on A beat 17 -> fetch completes, beat 17 data stored, error=1 with done=1; next start clears error.
4. rlast asserted on beat 62 of B -> beats continue to 64, error=1, done asserted.
5. start held high through DONE -> no second AR issued; after start drops, done=0 next cycle; a second start with new data updates both buffers.
6. rst pulsed during A beat 30 -> all outputs 0 within the reset cycle and state IDLE; a subsequent start runs a full clean fetch.

Source files
------------

// File: rtl/operand_fetch_controller_pkg.sv
// Constants and state type shared by the operand fetch and writeback stages.
package operand_fetch_controller_pkg;
  localparam int         WORD_W     = 32;
  localparam int         ADDR_W_DEF = 12;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [3:0] CACHE_DEF  = 4'b0011;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_DONE = 2'd3
  } fetch_state_e;
endpackage

// File: rtl/operand_fetch_controller_buffer.sv
// WORDS x DATA_W register bank, one indexed word written per enabled cycle.
module operand_buffer #(
  parameter int WORDS  = 64,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we_i,
  input  logic [7:0]              idx_i,
  input  logic [DATA_W-1:0]       wdata_i,
  output logic [WORDS*DATA_W-1:0] flat_o
);
  logic [WORDS*DATA_W-1:0] flat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       flat_q <= '0;
    else if (we_i) flat_q[int'(idx_i)*DATA_W +: DATA_W] <= wdata_i;
  end

  assign flat_o = flat_q;
endmodule

// File: rtl/operand_fetch_controller.sv
// Loads operands A and B for the systolic array with one AXI INCR read burst each.
//   state   | meaning
//   ST_IDLE | waiting for start, done low
//   ST_AR   | read address presented, waiting for arready
//   ST_R    | accepting WORDS beats into the buffer chosen by sel
//   ST_DONE | both operands loaded, done high until start drops
module operand_fetch_controller
  import operand_fetch_controller_pkg::*;
#(
  parameter int WORDS  = 64,
  parameter int DATA_W = WORD_W,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr_a,
  input  logic [ADDR_W-1:0]       base_addr_b,
  output logic [ADDR_W-1:0]       m_axi_araddr,
  output logic [1:0]              m_axi_arburst,
  output logic [3:0]              m_axi_arcache,
  output logic [7:0]              m_axi_arlen,
  output logic                    m_axi_arlock,
  output logic [2:0]              m_axi_arprot,
  output logic [2:0]              m_axi_arsize,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_W-1:0]       m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  output logic [WORDS*DATA_W-1:0] a_out_flat,
  output logic [WORDS*DATA_W-1:0] b_out_flat,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);
  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [ADDR_W-1:0] base_b_q, base_b_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic [7:0]        word_cnt_q, word_cnt_d;
  logic              sel_q, sel_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              busy_q;
  logic [1:0]        arburst_q;
  logic [3:0]        arcache_q;
  logic [7:0]        arlen_q;
  logic [2:0]        arsize_q;
  logic              beat_fire;
  logic              last_beat;

  assign last_beat = (word_cnt_q == 8'(WORDS - 1));

  always_comb begin
    state_d    = state_q;
    araddr_d   = araddr_q;
    base_b_d   = base_b_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    word_cnt_d = word_cnt_q;
    sel_d      = sel_q;
    done_d     = done_q;
    error_d    = error_q;
    beat_fire  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        done_d = 1'b0;
        if (start) begin
          base_b_d   = base_addr_b;
          araddr_d   = base_addr_a;
          arvalid_d  = 1'b1;
          word_cnt_d = 8'd0;
          sel_d      = 1'b0;
          error_d    = 1'b0;
          state_d    = ST_AR;
        end
      end
      ST_AR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_R;
        end
      end
      ST_R: begin
        if (m_axi_rvalid && rready_q) begin
          beat_fire  = 1'b1;
          word_cnt_d = word_cnt_q + 8'd1;
          if (m_axi_rresp != RESP_OKAY) error_d = 1'b1;
          // rlast is only checked for consistency; the burst ends on count
          if (m_axi_rlast != last_beat) error_d = 1'b1;
          if (last_beat) begin
            rready_d   = 1'b0;
            word_cnt_d = 8'd0;
            if (!sel_q) begin
              sel_d     = 1'b1;
              araddr_d  = base_b_q;
              arvalid_d = 1'b1;
              state_d   = ST_AR;
            end else begin
              done_d  = 1'b1;
              state_d = ST_DONE;
            end
          end
        end
      end
      ST_DONE: begin
        if (!start) begin
          done_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      araddr_q   <= '0;
      base_b_q   <= '0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      word_cnt_q <= 8'd0;
      sel_q      <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      busy_q     <= 1'b0;
      arburst_q  <= '0;
      arcache_q  <= '0;
      arlen_q    <= '0;
      arsize_q   <= '0;
    end else begin
      state_q    <= state_d;
      araddr_q   <= araddr_d;
      base_b_q   <= base_b_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      word_cnt_q <= word_cnt_d;
      sel_q      <= sel_d;
      done_q     <= done_d;
      error_q    <= error_d;
      busy_q     <= (state_d != ST_IDLE);
      arburst_q  <= arvalid_d ? BURST_INCR : 2'b00;
      arcache_q  <= arvalid_d ? CACHE_DEF : 4'b0000;
      arlen_q    <= arvalid_d ? 8'(WORDS - 1) : 8'd0;
      arsize_q   <= arvalid_d ? SIZE_4B : 3'b000;
    end
  end

  operand_buffer #(.WORDS(WORDS), .DATA_W(DATA_W)) u_buf_a (
    .clk     (clk),
    .rst     (rst),
    .we_i    (beat_fire && !sel_q),
    .idx_i   (word_cnt_q),
    .wdata_i (m_axi_rdata),
    .flat_o  (a_out_flat)
  );

  operand_buffer #(.WORDS(WORDS), .DATA_W(DATA_W)) u_buf_b (
    .clk     (clk),
    .rst     (rst),
    .we_i    (beat_fire && sel_q),
    .idx_i   (word_cnt_q),
    .wdata_i (m_axi_rdata),
    .flat_o  (b_out_flat)
  );

  assign m_axi_araddr  = araddr_q;
  assign m_axi_arburst = arburst_q;
  assign m_axi_arcache = arcache_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arsize  = arsize_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
endmodule

// File: tb/tb_operand_fetch_controller.sv
// Operand fetch controller bench: memory-backed AXI slave model with random stalls and fault injection.
module tb_operand_fetch_controller;
  localparam int WORDS = 64;
  localparam int DW    = 32;
  localparam int AW    = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [AW-1:0]     base_a, base_b;
  logic [AW-1:0]     araddr;
  logic [1:0]        arburst;
  logic [3:0]        arcache;
  logic [7:0]        arlen;
  logic              arlock;
  logic [2:0]        arprot;
  logic [2:0]        arsize;
  logic              arvalid, arready;
  logic [DW-1:0]     rdata;
  logic [1:0]        rresp;
  logic              rlast, rvalid, rready;
  logic [WORDS*DW-1:0] a_flat, b_flat;
  logic              busy, done, error;

  operand_fetch_controller #(.WORDS(WORDS), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .base_addr_a(base_a), .base_addr_b(base_b),
    .m_axi_araddr(araddr), .m_axi_arburst(arburst), .m_axi_arcache(arcache),
    .m_axi_arlen(arlen), .m_axi_arlock(arlock), .m_axi_arprot(arprot),
    .m_axi_arsize(arsize), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .a_out_flat(a_flat), .b_out_flat(b_flat),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [4096];
  logic [AW-1:0] q_addr[$];
  int            q_len[$];
  int beat_i, burst_idx, ar_wait, ar_count, total_beats;
  bit r_hold;
  int gap_pct, ar_delay, err_burst, err_beat, rl_burst, rl_beat;
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic slave_clear();
    q_addr.delete(); q_len.delete();
    beat_i = 0; burst_idx = 0; ar_wait = 0; ar_count = 0; total_beats = 0;
    r_hold = 0; rvalid = 0; arready = 0; rdata = '0; rresp = '0; rlast = 0;
  endtask

  // One clock of the slave model: drive inputs, clock, then score the cycle.
  task automatic step();
    logic hs, acc, pend;
    logic [AW-1:0] s_addr;
    logic [7:0] s_len;
    logic [2:0] s_size;
    logic [1:0] s_burst;
    logic [3:0] s_cache;
    logic [AW-1:0] ad;
    arready = arvalid && (ar_wait >= ar_delay);
    if (!r_hold) rvalid = (q_addr.size() != 0) && ($urandom_range(99) >= gap_pct);
    if (rvalid) begin
      ad    = q_addr[0] + AW'(beat_i);
      rdata = mem[ad];
      rresp = (burst_idx == err_burst && beat_i == err_beat) ? 2'b10 : 2'b00;
      rlast = (beat_i == q_len[0]) || (burst_idx == rl_burst && beat_i == rl_beat);
    end else begin
      rdata = '0; rresp = '0; rlast = 1'b0;
    end
    hs = arvalid && arready;
    pend = arvalid && !arready;
    acc = rvalid && rready;
    s_addr = araddr; s_len = arlen; s_size = arsize; s_burst = arburst; s_cache = arcache;
    @(posedge clk); #1;
    if (hs) begin
      chk("ar_addr", s_addr, (ar_count == 0) ? base_a : base_b);
      chk("ar_len", s_len, WORDS - 1);
      chk("ar_size", s_size, 3'b010);
      chk("ar_burst", s_burst, 2'b01);
      chk("ar_cache", s_cache, 4'b0011);
      chk("ar_lockprot", {arlock, arprot}, 4'b0000);
      q_addr.push_back(s_addr);
      q_len.push_back(int'(s_len));
      ar_count++;
      ar_wait = 0;
    end else if (pend) begin
      ar_wait++;
      chk("ar_hold_valid", arvalid, 1);
      chk("ar_hold_fields", {araddr, arlen, arsize, arburst, arcache},
          {s_addr, s_len, s_size, s_burst, s_cache});
    end
    if (acc) begin
      total_beats++;
      if (beat_i == q_len[0]) begin
        void'(q_addr.pop_front());
        void'(q_len.pop_front());
        beat_i = 0;
        burst_idx++;
      end else beat_i++;
    end
    r_hold = rvalid && !acc;
  endtask

  task automatic check_bufs(input string tag);
    logic [AW-1:0] ad;
    for (int i = 0; i < WORDS; i++) begin
      ad = base_a + AW'(i);
      chk($sformatf("%s_a[%0d]", tag, i), a_flat[i*DW +: DW], mem[ad]);
      ad = base_b + AW'(i);
      chk($sformatf("%s_b[%0d]", tag, i), b_flat[i*DW +: DW], mem[ad]);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
  endtask

  task automatic run_fetch(input string tag, input bit exp_err, input bit chk_lat, input int hold_start);
    int cyc;
    slave_clear();
    start = 1'b1;
    step();
    chk({tag, "_start_busy"}, busy, 1);
    chk({tag, "_start_arvalid"}, arvalid, 1);
    chk({tag, "_start_err_clr"}, error, 0);
    if (hold_start == 0) start = 1'b0;
    cyc = 0;
    while (!done && cyc < 4000) begin
      step();
      cyc++;
    end
    chk({tag, "_done"}, done, 1);
    if (chk_lat) chk({tag, "_latency"}, cyc, 2*WORDS + 2);
    chk({tag, "_error"}, error, exp_err);
    chk({tag, "_beats"}, total_beats, 2*WORDS);
    chk({tag, "_ar_count"}, ar_count, 2);
    check_bufs(tag);
    for (int k = 0; k < hold_start; k++) begin
      step();
      chk({tag, "_hold_done"}, done, 1);
      chk({tag, "_hold_no_ar"}, arvalid, 0);
    end
    if (hold_start != 0) chk({tag, "_hold_ar_count"}, ar_count, 2);
    start = 1'b0;
    step();
    chk({tag, "_done_clear"}, done, 0);
    chk({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    int cyc;
    rst = 1'b1; start = 1'b0; base_a = '0; base_b = '0;
    gap_pct = 0; ar_delay = 0; err_burst = -1; err_beat = -1; rl_burst = -1; rl_beat = -1;
    slave_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", {arvalid, rready, busy, done, error, araddr, arlen, arsize, arburst, arcache}, '0);
    n_assert++;
    assert (a_flat === '0 && b_flat === '0) else begin
      n_fail++; $error("FAIL rst_buffers: observed nonzero expected 0");
    end
    rst = 1'b0;
    step();

    // 1: zero-wait slave, known data, exact latency
    for (int i = 0; i < WORDS; i++) begin
      mem[12'h100 + i] = 32'hA000_0000 + i;
      mem[12'h200 + i] = 32'hB000_0000 + i;
    end
    base_a = 12'h100; base_b = 12'h200;
    run_fetch("t1", 0, 1, 0);

    // 2: random rvalid gaps and delayed arready
    gap_pct = 30; ar_delay = 5;
    run_fetch("t2", 0, 0, 0);

    // 3: SLVERR on A beat 17
    fill_random();
    gap_pct = 20; ar_delay = 1;
    err_burst = 0; err_beat = 17;
    base_a = AW'($urandom_range(0, 4095)); base_b = AW'($urandom_range(0, 4095));
    run_fetch("t3", 1, 0, 0);
    err_burst = -1; err_beat = -1;

    // 4: early rlast on B beat 62
    fill_random();
    rl_burst = 1; rl_beat = 62;
    run_fetch("t4", 0 | 1, 0, 0);
    rl_burst = -1; rl_beat = -1;

    // 5: start held through DONE, then a second fetch with new data
    fill_random();
    gap_pct = 10; ar_delay = 0;
    run_fetch("t5a", 0, 0, 10);
    fill_random();
    base_a = AW'($urandom_range(0, 4095)); base_b = AW'($urandom_range(0, 4095));
    run_fetch("t5b", 0, 0, 0);

    // 6: reset during A beat 30, then a clean fetch
    gap_pct = 0;
    slave_clear();
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    while (!(burst_idx == 0 && beat_i == 30) && cyc < 500) begin
      step();
      cyc++;
    end
    chk("t6_reached_beat30", beat_i, 30);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_outputs", {arvalid, rready, busy, done, error, araddr, arlen, arsize, arburst, arcache}, '0);
    n_assert++;
    assert (a_flat === '0 && b_flat === '0) else begin
      n_fail++; $error("FAIL t6_rst_buffers: observed nonzero expected 0");
    end
    @(posedge clk); #1;
    rst = 1'b0;
    slave_clear();
    step();
    chk("t6_idle_after_rst", {busy, arvalid}, 2'b00);
    fill_random();
    run_fetch("t6", 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
